// File: rtl/player_input_ctrl.sv
// player_input_ctrl: maps USB keycode slots to per-player actions through a runtime-writable key map.
// Latency: keycodes registered once, decoded combinationally, latched on the vsync rising edge; outputs change one cycle after the edge.
// Backpressure: none; outputs are frame-latched registers that hold steady between frame ticks.
//
// Ports:
//   clk, reset            pixel clock, asynchronous active-high reset
//   vsync                 VGA vsync (same clock domain); its rising edge is the frame strobe
//   keycodes              NUM_SLOTS HID usage codes, slot i at [8i+7:8i], 0x00 = empty
//   cfg_we/player/action/code   key-map write port (out-of-range player/action writes are dropped)
//   frame_tick            one-cycle pulse in the cycle the frame outputs update
//   held/pressed          bit [6p+a]: resolved action held / newly pressed this frame
//   hold_cnt              field [(6p+a)*HOLD_W +: HOLD_W]: saturating frames-held count
//   special               per-player back, forward, punch combo recognised this frame
//
// Optional feature: define SPECIAL_MOVE_EN to build the per-player combo recogniser.
// Without it, special is tied to zero and no combo logic exists.
//
// Action index a: 0 forward, 1 back, 2 jump, 3 squat, 4 punch, 5 kick.

module player_input_ctrl #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_SLOTS   = 6,
    parameter int HOLD_W      = 6,
    parameter int COMBO_WIN   = 8,
    localparam int PW         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              vsync,
    input  logic [8*NUM_SLOTS-1:0]            keycodes,
    input  logic                              cfg_we,
    input  logic [PW-1:0]                     cfg_player,
    input  logic [2:0]                        cfg_action,
    input  logic [7:0]                        cfg_code,
    output logic                              frame_tick,
    output logic [6*NUM_PLAYERS-1:0]          held,
    output logic [6*NUM_PLAYERS-1:0]          pressed,
    output logic [6*NUM_PLAYERS*HOLD_W-1:0]   hold_cnt,
    output logic [NUM_PLAYERS-1:0]            special
);

    localparam int NA = 6;                   // actions per player
    localparam int NB = NA * NUM_PLAYERS;    // total action bits

    localparam int A_FWD   = 0;
    localparam int A_BACK  = 1;
    localparam int A_JUMP  = 2;
    localparam int A_SQUAT = 3;
    localparam int A_PUNCH = 4;

    // Default maps, action 0 in the least significant byte.
    localparam logic [47:0] P0_MAP = {8'h0E, 8'h0D, 8'h16, 8'h1A, 8'h04, 8'h07};
    localparam logic [47:0] P1_MAP = {8'h5A, 8'h59, 8'h51, 8'h52, 8'h50, 8'h4F};

    function automatic logic [8*NB-1:0] map_defaults();
        logic [8*NB-1:0] m;
        m = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (p == 0) begin
                m[48*p +: 48] = P0_MAP;
            end else if (p == 1) begin
                m[48*p +: 48] = P1_MAP;
            end
        end
        return m;
    endfunction

    localparam logic [8*NB-1:0] MAP_RST = map_defaults();

    // ------------------------------------------------------------------
    // Registered inputs and frame strobe
    // ------------------------------------------------------------------
    logic [8*NUM_SLOTS-1:0]   r_kc_q;
    logic                     r_vs_q;
    logic                     w_strobe;

    // vs_q resets high so a vsync already high at reset release is not a strobe.
    assign w_strobe = vsync & ~r_vs_q;

    // ------------------------------------------------------------------
    // Key map
    // ------------------------------------------------------------------
    logic [8*NB-1:0]          r_map;
    logic                     w_cfg_ok;

    assign w_cfg_ok = cfg_we && (cfg_action <= 3'd5) && (32'(cfg_player) < NUM_PLAYERS);

    // The map updates on the same edge that latches a coincident strobe,
    // so that strobe naturally decodes against the old map.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_map <= MAP_RST;
        end else if (w_cfg_ok) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                for (int a = 0; a < NA; a++) begin
                    if (cfg_player == PW'(p) && cfg_action == 3'(a)) begin
                        r_map[8*(NA*p + a) +: 8] <= cfg_code;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Raw match and opposing-direction resolution
    // ------------------------------------------------------------------
    logic [NB-1:0]            w_raw;
    logic [NB-1:0]            w_res;
    logic [NB-1:0]            w_pressed_nxt;
    logic [NB*HOLD_W-1:0]     w_cnt_nxt;

    // A zero map entry is "unbound" and must never match an empty slot.
    always_comb begin
        w_raw = '0;
        for (int i = 0; i < NB; i++) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (r_map[8*i +: 8] != 8'h00 && r_kc_q[8*s +: 8] == r_map[8*i +: 8]) begin
                    w_raw[i] = 1'b1;
                end
            end
        end
    end

    // Both directions of an opposing pair cancel to neutral.
    always_comb begin
        w_res = w_raw;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (w_raw[NA*p + A_FWD] && w_raw[NA*p + A_BACK]) begin
                w_res[NA*p + A_FWD]  = 1'b0;
                w_res[NA*p + A_BACK] = 1'b0;
            end
            if (w_raw[NA*p + A_JUMP] && w_raw[NA*p + A_SQUAT]) begin
                w_res[NA*p + A_JUMP]  = 1'b0;
                w_res[NA*p + A_SQUAT] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next frame values
    // ------------------------------------------------------------------
    logic [NB-1:0]            r_held;
    logic [NB-1:0]            r_pressed;
    logic [NB*HOLD_W-1:0]     r_cnt;
    logic                     r_tick;

    assign w_pressed_nxt = w_res & ~r_held;

    always_comb begin
        logic [HOLD_W-1:0] v_cur;
        w_cnt_nxt = '0;
        v_cur     = '0;
        for (int i = 0; i < NB; i++) begin
            v_cur = r_cnt[HOLD_W*i +: HOLD_W];
            if (w_res[i]) begin
                w_cnt_nxt[HOLD_W*i +: HOLD_W] = (v_cur == {HOLD_W{1'b1}}) ? v_cur
                                                                           : v_cur + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kc_q    <= '0;
            r_vs_q    <= 1'b1;
            r_tick    <= 1'b0;
            r_held    <= '0;
            r_pressed <= '0;
            r_cnt     <= '0;
        end else begin
            r_kc_q <= keycodes;
            r_vs_q <= vsync;
            r_tick <= w_strobe;
            if (w_strobe) begin
                r_held    <= w_res;
                r_pressed <= w_pressed_nxt;
                r_cnt     <= w_cnt_nxt;
            end
        end
    end

    assign frame_tick = r_tick;
    assign held       = r_held;
    assign pressed    = r_pressed;
    assign hold_cnt   = r_cnt;

    // ------------------------------------------------------------------
    // Special-move recogniser: back, then forward, then punch, each step
    // within COMBO_WIN frames of the previous one.
    // ------------------------------------------------------------------
`ifdef SPECIAL_MOVE_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GOT_BACK = 2'd1,
        ST_GOT_FWD  = 2'd2
    } combo_state_t;

    localparam logic [7:0] WIN = 8'(COMBO_WIN);

    combo_state_t [NUM_PLAYERS-1:0]   r_state;
    combo_state_t [NUM_PLAYERS-1:0]   w_state_nxt;
    logic [NUM_PLAYERS-1:0][7:0]      r_timer;
    logic [NUM_PLAYERS-1:0][7:0]      w_timer_nxt;
    logic [NUM_PLAYERS-1:0]           r_special;
    logic [NUM_PLAYERS-1:0]           w_special_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                r_state[p] <= ST_IDLE;
            end
            r_timer   <= '0;
            r_special <= '0;
        end else if (w_strobe) begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_special <= w_special_nxt;
        end
    end

    // Evaluated on the freshly computed pressed bits so the combo advances
    // in the same frame the step key goes down.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_special_nxt = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (r_state[p] == ST_GOT_FWD && w_pressed_nxt[NA*p + A_PUNCH]) begin
                // Completing punch; a simultaneous back starts the next combo.
                w_special_nxt[p] = 1'b1;
                w_state_nxt[p]   = w_pressed_nxt[NA*p + A_BACK] ? ST_GOT_BACK : ST_IDLE;
                w_timer_nxt[p]   = 8'd0;
            end else if (w_pressed_nxt[NA*p + A_BACK]) begin
                w_state_nxt[p] = ST_GOT_BACK;
                w_timer_nxt[p] = 8'd0;
            end else if (r_state[p] == ST_GOT_BACK && w_pressed_nxt[NA*p + A_FWD]) begin
                w_state_nxt[p] = ST_GOT_FWD;
                w_timer_nxt[p] = 8'd0;
            end else if (r_state[p] != ST_IDLE) begin
                if (r_timer[p] + 8'd1 == WIN) begin
                    w_state_nxt[p] = ST_IDLE;
                    w_timer_nxt[p] = 8'd0;
                end else begin
                    w_timer_nxt[p] = r_timer[p] + 8'd1;
                end
            end
        end
    end

    assign special = r_special;
`else
    assign special = '0;
`endif

endmodule

// File: tb/tb_player_input_ctrl.sv
// tb_player_input_ctrl: randomized and directed stimulus against a frame-level reference model.
// Expected frames are queued at each vsync rise; a monitor pops them on frame_tick.
// Between ticks the monitor requires every output to hold its last frame value.

module tb_player_input_ctrl;

    localparam int NP = 2;
    localparam int NS = 6;
    localparam int HW = 6;
    localparam int CW = 8;
    localparam int NA = 6;
    localparam int NB = NA * NP;
    localparam int CMAX = (1 << HW) - 1;
    localparam int NONE = -1000000;

    localparam logic [7:0] DEF0 [NA] = '{8'h07, 8'h04, 8'h1A, 8'h16, 8'h0D, 8'h0E};
    localparam logic [7:0] DEF1 [NA] = '{8'h4F, 8'h50, 8'h52, 8'h51, 8'h59, 8'h5A};
    localparam logic [7:0] POOL [15] = '{8'h07, 8'h04, 8'h1A, 8'h16, 8'h0D, 8'h0E, 8'h4F,
                                         8'h50, 8'h52, 8'h51, 8'h59, 8'h5A, 8'h2C, 8'h00, 8'h33};

    logic              clk = 1'b0;
    logic              reset;
    logic              vsync;
    logic [8*NS-1:0]   keycodes;
    logic              cfg_we;
    logic [0:0]        cfg_player;
    logic [2:0]        cfg_action;
    logic [7:0]        cfg_code;
    logic              frame_tick;
    logic [NB-1:0]     held;
    logic [NB-1:0]     pressed;
    logic [NB*HW-1:0]  hold_cnt;
    logic [NP-1:0]     special;

    always #5 clk = ~clk;

    player_input_ctrl #(
        .NUM_PLAYERS (NP),
        .NUM_SLOTS   (NS),
        .HOLD_W      (HW),
        .COMBO_WIN   (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .keycodes   (keycodes),
        .cfg_we     (cfg_we),
        .cfg_player (cfg_player),
        .cfg_action (cfg_action),
        .cfg_code   (cfg_code),
        .frame_tick (frame_tick),
        .held       (held),
        .pressed    (pressed),
        .hold_cnt   (hold_cnt),
        .special    (special)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NB-1:0]    held;
        logic [NB-1:0]    pressed;
        logic [NB*HW-1:0] cnt;
        logic [NP-1:0]    special;
        int               cyc;
    } exp_t;

    exp_t q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // ------------------------------------------------------------------
    // Reference model: per-frame decode from the key map and slot list,
    // special moves as "each step within CW frames of the previous step".
    // ------------------------------------------------------------------
    logic [7:0] m_map [NP][NA];
    bit         m_held [NP][NA];
    int         m_cnt [NP][NA];
    int         m_bframe [NP];
    int         m_fframe [NP];
    int         m_frame;

    function automatic void model_reset();
        for (int a = 0; a < NA; a++) begin
            m_map[0][a] = DEF0[a];
            m_map[1][a] = DEF1[a];
        end
        for (int p = 0; p < NP; p++) begin
            for (int a = 0; a < NA; a++) begin
                m_held[p][a] = 1'b0;
                m_cnt[p][a]  = 0;
            end
            m_bframe[p] = NONE;
            m_fframe[p] = NONE;
        end
        m_frame = 0;
    endfunction

    function automatic void model_write(input int wp, input int wa, input logic [7:0] wc);
        if (wa <= 5 && wp < NP) m_map[wp][wa] = wc;
    endfunction

    function automatic exp_t model_frame(input logic [8*NS-1:0] kc);
        exp_t e;
        bit   raw [NA];
        bit   res, fb, js, pb, pf, pp;
        e.held    = '0;
        e.pressed = '0;
        e.cnt     = '0;
        e.special = '0;
        e.cyc     = 0;
        m_frame++;
        for (int p = 0; p < NP; p++) begin
            for (int a = 0; a < NA; a++) begin
                raw[a] = 1'b0;
                for (int s = 0; s < NS; s++)
                    if (m_map[p][a] != 8'h00 && kc[8*s +: 8] == m_map[p][a]) raw[a] = 1'b1;
            end
            fb = raw[0] && raw[1];
            js = raw[2] && raw[3];
            for (int a = 0; a < NA; a++) begin
                res = raw[a] && !((a < 2) ? fb : ((a < 4) ? js : 1'b0));
                e.held[NA*p + a]    = res;
                e.pressed[NA*p + a] = res && !m_held[p][a];
                m_cnt[p][a] = res ? ((m_cnt[p][a] + 1 > CMAX) ? CMAX : m_cnt[p][a] + 1) : 0;
                e.cnt[HW*(NA*p + a) +: HW] = HW'(m_cnt[p][a]);
                m_held[p][a] = res;
            end
            pf = e.pressed[NA*p + 0];
            pb = e.pressed[NA*p + 1];
            pp = e.pressed[NA*p + 4];
            if (pp && m_fframe[p] != NONE && m_frame - m_fframe[p] <= CW) begin
                e.special[p] = 1'b1;
                m_fframe[p]  = NONE;
                m_bframe[p]  = pb ? m_frame : NONE;
            end else if (pb) begin
                m_bframe[p] = m_frame;
                m_fframe[p] = NONE;
            end else if (pf && m_fframe[p] == NONE && m_bframe[p] != NONE
                         && m_frame - m_bframe[p] <= CW) begin
                m_fframe[p] = m_frame;
                m_bframe[p] = NONE;
            end
        end
`ifndef SPECIAL_MOVE_EN
        e.special = '0;
`endif
        return e;
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    exp_t last;

    always @(negedge clk) begin
        if (reset) begin
            check("rst_tick", 128'(frame_tick), 128'(0));
            check("rst_held", 128'(held), 128'(0));
            check("rst_pressed", 128'(pressed), 128'(0));
            check("rst_hold_cnt", 128'(hold_cnt), 128'(0));
            check("rst_special", 128'(special), 128'(0));
            last.held    = '0;
            last.pressed = '0;
            last.cnt     = '0;
            last.special = '0;
        end else if (frame_tick) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_tick: got frame_tick=1, required 0 (cycle %0d)", cyc);
            end else begin
                last = q.pop_front();
                check("tick_latency", 128'(cyc), 128'(last.cyc + 1));
                check("held", 128'(held), 128'(last.held));
                check("pressed", 128'(pressed), 128'(last.pressed));
                check("hold_cnt", 128'(hold_cnt), 128'(last.cnt));
                check("special", 128'(special), 128'(last.special));
            end
        end else begin
            check("stable_held", 128'(held), 128'(last.held));
            check("stable_pressed", 128'(pressed), 128'(last.pressed));
            check("stable_hold_cnt", 128'(hold_cnt), 128'(last.cnt));
            check("stable_special", 128'(special), 128'(last.special));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [8*NS-1:0] kc, input bit wr, input int wp,
                         input int wa, input logic [7:0] wc);
        exp_t e;
        keycodes = kc;
        repeat (3) tick();
        e     = model_frame(kc);
        e.cyc = cyc;
        q.push_back(e);
        vsync = 1'b1;
        if (wr) begin
            cfg_we     = 1'b1;
            cfg_player = 1'(wp);
            cfg_action = 3'(wa);
            cfg_code   = wc;
            model_write(wp, wa, wc);
        end
        tick();
        cfg_we = 1'b0;
        repeat (2) tick();
        vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic kframe(input logic [8*NS-1:0] kc);
        frame(kc, 1'b0, 0, 0, 8'h00);
    endtask

    task automatic cfg_write(input int wp, input int wa, input logic [7:0] wc);
        cfg_we     = 1'b1;
        cfg_player = 1'(wp);
        cfg_action = 3'(wa);
        cfg_code   = wc;
        model_write(wp, wa, wc);
        tick();
        cfg_we = 1'b0;
        tick();
    endtask

    task automatic rand_frame();
        logic [8*NS-1:0] kc;
        kc = '0;
        for (int s = 0; s < NS; s++)
            if ($urandom_range(0, 1) == 1) kc[8*s +: 8] = POOL[$urandom_range(0, 14)];
        frame(kc, $urandom_range(0, 5) == 0, int'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), POOL[$urandom_range(0, 14)]);
    endtask

    initial begin
        reset      = 1'b1;
        vsync      = 1'b1;
        keycodes   = '0;
        cfg_we     = 1'b0;
        cfg_player = '0;
        cfg_action = '0;
        cfg_code   = '0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        // vsync already high out of reset: no strobe allowed.
        repeat (5) tick();
        vsync = 1'b0;
        repeat (3) tick();

        kframe('0);
        kframe('0);
        // D held three frames, then released.
        repeat (3) kframe(48'h07);
        kframe('0);
        // A and D together cancel; P1 jump alone.
        kframe(48'h0000_0700_0004);
        kframe(48'h52);
        // Remap P1 punch in the strobe cycle: that frame still decodes 0x59.
        frame(48'h59, 1'b1, 1, 4, 8'h2C);
        kframe(48'h59);
        kframe(48'h2C);
        // Out-of-range action write between strobes changes nothing.
        cfg_write(0, 6, 8'h00);
        cfg_write(1, 7, 8'h07);
        kframe(48'h07);
        // Long hold reaches saturation.
        repeat (66) kframe(48'h0D);
        kframe('0);
        // Combo A, D, J on consecutive frames.
        repeat (10) kframe('0);
        kframe(48'h04);
        kframe(48'h07);
        kframe(48'h0D);
        kframe('0);
        // Same combo with a 9-frame gap after A.
        repeat (10) kframe('0);
        kframe(48'h04);
        repeat (9) kframe('0);
        kframe(48'h07);
        kframe(48'h0D);
        kframe('0);

        repeat (80) rand_frame();

        // Mid-frame reset restores the default map.
        cfg_write(0, 0, 8'h33);
        keycodes = 48'h07;
        repeat (2) tick();
        reset = 1'b1;
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        kframe(48'h07);
        kframe(48'h33);
        kframe(48'h4F);
        repeat (5) tick();

        check("queue_drain", 128'(q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
